// File: rtl/aes_pkg.sv
// Shared AES types and constants for the round pipeline.
// Block and key widths are fixed at 128 bits.
package aes_pkg;
    localparam int AES_BLOCK_W = 128;

    typedef logic [AES_BLOCK_W-1:0] aes_state_t;
    typedef logic [AES_BLOCK_W-1:0] aes_key_t;
endpackage

// File: rtl/aes_skid_buffer.sv
// Generic 2-entry valid/ready register slice.
// Output register plus one skid entry; o_ready comes straight from a flop.
module aes_skid_buffer #(
    parameter int WIDTH = 128
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    input  logic             i_ready
);
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_skid_data;
    logic             r_skid_valid;
    logic             r_ready;

    logic w_in_xfer;
    logic w_out_free;

    assign w_in_xfer  = i_valid && r_ready;
    assign w_out_free = !r_out_valid || i_ready;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
            r_skid_data  <= '0;
            r_skid_valid <= 1'b0;
            r_ready      <= 1'b1;
        end else if (w_out_free) begin
            // A full skid implies r_ready=0, so no input can arrive here
            if (r_skid_valid) begin
                r_out_data   <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
                r_ready      <= 1'b1;
            end else if (w_in_xfer) begin
                r_out_data  <= i_data;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_data  <= i_data;
            r_skid_valid <= 1'b1;
            r_ready      <= 1'b0;
        end
    end

    assign o_ready = r_ready;
    assign o_data  = r_out_data;
    assign o_valid = r_out_valid;
endmodule

// File: rtl/aes_add_round_key.sv
// Registered AES AddRoundKey: state XOR round key, valid/ready on both sides.
// Same stage serves encrypt, decrypt and round-0 whitening.
module aes_add_round_key
    import aes_pkg::*;
#(
    parameter int BLOCK_W = AES_BLOCK_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [BLOCK_W-1:0] i_state,
    input  logic [BLOCK_W-1:0] i_key,
    input  logic               i_valid,
    output logic               o_ready,
    output logic [BLOCK_W-1:0] o_state,
    output logic               o_valid,
    input  logic               i_ready
);
    aes_state_t w_sum;

    assign w_sum = i_state ^ i_key;

    aes_skid_buffer #(
        .WIDTH (BLOCK_W)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_data  (w_sum),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_data  (o_state),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );
endmodule

// File: tb/tb_aes_add_round_key.sv
// Bench for aes_add_round_key: scoreboard queue fed by the driver,
// drained by a monitor on each output transfer.
module tb_aes_add_round_key;
    logic         clk;
    logic         rst_n;
    logic [127:0] i_state;
    logic [127:0] i_key;
    logic         i_valid;
    logic         o_ready;
    logic [127:0] o_state;
    logic         o_valid;
    logic         i_ready;

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] sb[$];
    logic [127:0] exp_m;
    logic         chk_stream = 1'b0;

    aes_add_round_key dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_state (i_state),
        .i_key   (i_key),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_state (o_state),
        .o_valid (o_valid),
        .i_ready (i_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: AddRoundKey is a byte-wise XOR of state and key
    function automatic logic [127:0] ref_ark(input logic [127:0] s,
                                             input logic [127:0] k);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 16; b++)
            r[127-8*b -: 8] = s[127-8*b -: 8] ^ k[127-8*b -: 8];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] s, input logic [127:0] k,
                        input logic [127:0] exp, output int waits);
        logic acc;
        i_state = s;
        i_key   = k;
        i_valid = 1'b1;
        waits   = 0;
        forever begin
            @(negedge clk);
            acc = o_ready;
            @(posedge clk);
            if (acc) begin
                sb.push_back(exp);
                break;
            end
            waits++;
            if (waits > 20) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got o_ready=0 for %0d cycles expected acceptance", waits);
                break;
            end
        end
        #1;
        i_valid = 1'b0;
        i_state = rnd128();
        i_key   = rnd128();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: every output transfer must match the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (chk_stream && !o_valid) begin
                n_tests++;
                n_fail++;
                $display("FAIL stream_gap: got o_valid=0 expected 1");
            end
            if (o_valid && i_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h expected no output", o_state);
                end else begin
                    exp_m = sb.pop_front();
                    check("out_data", o_state, exp_m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        logic [127:0] va, vb, vc, s, k;

        rst_n   = 1'b0;
        i_state = '0;
        i_key   = '0;
        i_valid = 1'b1;
        i_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {127'd0, o_valid}, 128'd0);
        check("rst_ready", {127'd0, o_ready}, 128'd1);
        check("rst_state", o_state, 128'd0);
        rst_n = 1'b1;

        send('0, '0, 128'd0, w);
        check("first_valid", {127'd0, o_valid}, 128'd1);
        check("first_state", o_state, 128'd0);

        // FIPS-197 round-0 vector, identity, inversion
        send(128'h3243f6a8885a308d313198a2e0370734,
             128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h193de3bea0f4e22b9ac68d2ae9f84808, w);
        send({128{1'b1}}, 128'd0, {128{1'b1}}, w);
        send(128'h193de3bea0f4e22b9ac68d2ae9f84808,
             128'h2b7e151628aed2a6abf7158809cf4f3c,
             128'h3243f6a8885a308d313198a2e0370734, w);
        idle(3);
        check("drain1_empty", {127'd0, o_valid}, 128'd0);

        // Backpressure: three vectors with i_ready held low
        va = rnd128(); vb = rnd128(); vc = rnd128();
        k  = rnd128();
        i_ready = 1'b0;
        send(va, k, ref_ark(va, k), w);
        check("bp_acc_a", w, 0);
        send(vb, k, ref_ark(vb, k), w);
        check("bp_acc_b", w, 0);
        i_state = vc;
        i_key   = k;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_ready_low", {127'd0, o_ready}, 128'd0);
            check("bp_hold", o_state, ref_ark(va, k));
            @(posedge clk);
        end
        #1;
        i_ready = 1'b1;
        @(negedge clk);
        check("rel_ready0", {127'd0, o_ready}, 128'd0);
        check("rel_valid0", {127'd0, o_valid}, 128'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_ready1", {127'd0, o_ready}, 128'd1);
        check("rel_valid1", {127'd0, o_valid}, 128'd1);
        @(posedge clk);
        sb.push_back(ref_ark(vc, k));
        #1;
        i_valid = 1'b0;
        @(negedge clk);
        check("rel_valid2", {127'd0, o_valid}, 128'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rel_empty", {127'd0, o_valid}, 128'd0);
        check("rel_sb_empty", 128'(sb.size()), 128'd0);
        @(posedge clk);
        #1;

        // Full-rate streaming
        for (int i = 0; i < 16; i++) begin
            s = rnd128();
            k = rnd128();
            send(s, k, ref_ark(s, k), w);
            check("stream_nowait", w, 0);
            if (i == 0) chk_stream = 1'b1;
        end
        @(posedge clk);
        #1;
        chk_stream = 1'b0;
        idle(2);
        check("stream_sb_empty", 128'(sb.size()), 128'd0);

        // Reset while two entries are held
        i_ready = 1'b0;
        s = rnd128();
        send(s, k, ref_ark(s, k), w);
        s = rnd128();
        send(s, k, ref_ark(s, k), w);
        idle(1);
        check("pre_rst_ready", {127'd0, o_ready}, 128'd0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {127'd0, o_valid}, 128'd0);
        check("mid_rst_ready", {127'd0, o_ready}, 128'd1);
        check("mid_rst_state", o_state, 128'd0);
        sb.delete();
        i_ready = 1'b1;
        idle(2);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("post_rst_valid", {127'd0, o_valid}, 128'd0);
            @(posedge clk);
        end
        #1;
        s = rnd128();
        k = rnd128();
        send(s, k, ref_ark(s, k), w);
        idle(3);
        check("final_sb_empty", 128'(sb.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
